// File: rtl/sm_add.sv
// Bit-serial sign-magnitude adder that reconstructs the minuend A from (buho, diff, B).
// Optional self-check against a reference minuend is enabled with the macro SM_ADD_CHECK_EN.
module sm_add #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             buho,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] B,
`ifdef SM_ADD_CHECK_EN
  input  logic [WIDTH-1:0] a_ref,
  output logic             mismatch,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] A,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             carry_r, carry_s;
  logic             sub_r, sub_s;
  logic [WIDTH-1:0] b_sh_r, b_sh_s;
  logic [WIDTH-1:0] d_sh_r, d_sh_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic             ovf_r, ovf_s;

  logic             bit_b_s, bit_d_s;
  logic             sum_bit_s, cout_s;
  logic [WIDTH-1:0] res_shift_s;

`ifdef SM_ADD_CHECK_EN
  logic [WIDTH-1:0] ref_r, ref_s;
  logic             mismatch_r, mismatch_s;
`endif

  // Next-state, datapath and output logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    carry_s  = carry_r;
    sub_s    = sub_r;
    b_sh_s   = b_sh_r;
    d_sh_s   = d_sh_r;
    res_s    = res_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    a_s      = a_r;
    ovf_s    = ovf_r;
`ifdef SM_ADD_CHECK_EN
    ref_s      = ref_r;
    mismatch_s = mismatch_r;
`endif

    bit_b_s   = b_sh_r[0];
    bit_d_s   = d_sh_r[0];
    sum_bit_s = bit_b_s ^ bit_d_s ^ carry_r;
    // Same sum bit for add and subtract; only the carry/borrow chain differs.
    if (sub_r) begin
      cout_s = (~bit_b_s & bit_d_s) | (~(bit_b_s ^ bit_d_s) & carry_r);
    end else begin
      cout_s = (bit_b_s & bit_d_s) | (bit_b_s & carry_r) | (bit_d_s & carry_r);
    end
    res_shift_s = {sum_bit_s, res_r[WIDTH-1:1]};

    case (state_r)
      IDLE: begin
        if (start) begin
          sub_s   = buho;
          b_sh_s  = B;
          d_sh_s  = diff;
          res_s   = {WIDTH{1'b0}};
          carry_s = 1'b0;
          cnt_s   = CNT_ZERO;
          busy_s  = 1'b1;
          state_s = CALC;
`ifdef SM_ADD_CHECK_EN
          ref_s   = a_ref;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        res_s   = res_shift_s;
        b_sh_s  = {1'b0, b_sh_r[WIDTH-1:1]};
        d_sh_s  = {1'b0, d_sh_r[WIDTH-1:1]};
        carry_s = cout_s;
        cnt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          a_s     = res_shift_s;
          ovf_s   = cout_s;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
`ifdef SM_ADD_CHECK_EN
          mismatch_s = (res_shift_s != ref_r) | cout_s;
`endif
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      b_sh_r  <= {WIDTH{1'b0}};
      d_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
`ifdef SM_ADD_CHECK_EN
      ref_r      <= {WIDTH{1'b0}};
      mismatch_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      carry_r <= carry_s;
      sub_r   <= sub_s;
      b_sh_r  <= b_sh_s;
      d_sh_r  <= d_sh_s;
      res_r   <= res_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      a_r     <= a_s;
      ovf_r   <= ovf_s;
`ifdef SM_ADD_CHECK_EN
      ref_r      <= ref_s;
      mismatch_r <= mismatch_s;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign A    = a_r;
  assign ovf  = ovf_r;
`ifdef SM_ADD_CHECK_EN
  assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_sm_add.sv
// Scoreboard bench for sm_add (WIDTH=4): directed vectors push expectations, a monitor checks each done.
module tb_sm_add;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       n_rst, start, buho;
  logic [3:0] diff, B, A;
  logic       busy, done, ovf;
`ifdef SM_ADD_CHECK_EN
  logic [3:0] a_ref;
  logic       mismatch;
`endif

  sm_add #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .buho(buho), .diff(diff), .B(B),
`ifdef SM_ADD_CHECK_EN
    .a_ref(a_ref), .mismatch(mismatch),
`endif
    .busy(busy), .done(done), .A(A), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic       ovf;
    logic       mm;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: done=1 with no pending vector (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("A", {28'd0, A}, {28'd0, e.a});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("latency", cyc, e.cyc);
`ifdef SM_ADD_CHECK_EN
        check("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
`endif
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [3:0] b, input logic sub, input logic [3:0] d,
                       input logic [3:0] aref, input logic [3:0] ea, input logic eo,
                       input logic emm, input bit scramble);
    @(negedge clk);
    B = b; buho = sub; diff = d; start = 1'b1;
`ifdef SM_ADD_CHECK_EN
    a_ref = aref;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{ea, eo, emm, cyc + WIDTH});
    if (scramble) begin
      B = 4'd0; diff = 4'd0; buho = ~sub;
`ifdef SM_ADD_CHECK_EN
      a_ref = 4'd0;
`endif
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: %0d vectors still pending", name, sb.size());
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; buho = 1'b0; diff = 4'd0; B = 4'd0;
`ifdef SM_ADD_CHECK_EN
    a_ref = 4'd0;
`endif
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_A", {28'd0, A}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`ifdef SM_ADD_CHECK_EN
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 3 + 1 = 4, with busy held for the 4 CALC cycles
    issue(4'd3, 1'b0, 4'd1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("calc_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("done_busy_low", {31'd0, busy}, 32'd0);
    wait_drain("add_3_1");

    // 5 - 3 = 2, operands scrambled after the start edge
    issue(4'd5, 1'b1, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    wait_drain("sub_5_3");
    repeat (3) @(negedge clk);
    check("A_hold", {28'd0, A}, 32'd2);

    // 2 + 2 = 4 against a matching reference
    issue(4'd2, 1'b0, 4'd2, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    wait_drain("add_2_2");
    // degenerate subtract of zero: A = B
    issue(4'd9, 1'b1, 4'd0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    wait_drain("sub_9_0");
    // 15 + 1 wraps to 0 with ovf
    issue(4'd15, 1'b0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    wait_drain("add_15_1");
    // 2 - 3 wraps to 15 with borrow; reference 4 disagrees
    issue(4'd2, 1'b1, 4'd3, 4'd4, 4'd15, 1'b1, 1'b1, 1'b0);
    wait_drain("sub_2_3");

    // Reset during the second CALC cycle clears everything immediately
    @(negedge clk);
    B = 4'd3; buho = 1'b0; diff = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_A", {28'd0, A}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // start held high for 12 edges: exactly two runs, 6 cycles apart
    @(negedge clk);
    B = 4'd2; buho = 1'b0; diff = 4'd2; start = 1'b1;
`ifdef SM_ADD_CHECK_EN
    a_ref = 4'd4;
`endif
    @(posedge clk);
    #1;
    sb.push_back('{4'd4, 1'b0, 1'b0, cyc + 4});
    sb.push_back('{4'd4, 1'b0, 1'b0, cyc + 10});
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    wait_drain("back_to_back");
    repeat (8) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
